// File: rtl/fishing_pkg.sv
`default_nettype none
// ============================================================================
// Module : fishing_pkg
// Colours, screen geometry, FSM states and per-level fish tables.
// Rev    : 1.0
// ============================================================================
package fishing_pkg;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GREEN  = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] ORANGE = 12'hF80;
    localparam logic [11:0] BROWN  = 12'h840;
    localparam logic [11:0] YELLOW = 12'hFF0;

    typedef enum logic [1:0] {
        S_FISH = 2'd0,
        S_REEL = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_e;

    localparam logic [1:0] ST_FISH = S_FISH;
    localparam logic [1:0] ST_REEL = S_REEL;
    localparam logic [1:0] ST_WIN  = S_WIN;
    localparam logic [1:0] ST_LOSE = S_LOSE;

    localparam logic [9:0] H_MIN       = 10'd144;
    localparam logic [9:0] H_MAX       = 10'd798;
    localparam logic [9:0] ROD_X_MIN   = 10'd312;
    localparam logic [9:0] ROD_X_MAX   = 10'd798;
    localparam logic [9:0] ROD_X_RESET = 10'd450;
    localparam logic [9:0] SURFACE_Y   = 10'd155;
    localparam logic [9:0] CATCH_Y     = 10'd106;
    localparam logic [9:0] LINE_TOP    = 10'd75;
    localparam logic [9:0] SUN_X       = 10'd720;
    localparam logic [9:0] SUN_Y       = 10'd55;
    localparam logic [9:0] SUN_SIZE    = 10'd40;

    // 470 - 90k goes negative past level 5; those levels reuse the top row.
    function automatic logic [9:0] fish_y(input logic [2:0] k);
        case (k)
            3'd0:    fish_y = 10'd470;
            3'd1:    fish_y = 10'd380;
            3'd2:    fish_y = 10'd290;
            3'd3:    fish_y = 10'd200;
            3'd4:    fish_y = 10'd110;
            default: fish_y = 10'd20;
        endcase
    endfunction

    function automatic logic [9:0] fish_half_h(input logic [2:0] k);
        case (k)
            3'd0:    fish_half_h = 10'd10;
            3'd1:    fish_half_h = 10'd8;
            3'd2:    fish_half_h = 10'd5;
            default: fish_half_h = 10'd3;
        endcase
    endfunction

    function automatic logic [9:0] fish_width(input logic [2:0] k);
        case (k)
            3'd0:    fish_width = 10'd60;
            3'd1:    fish_width = 10'd40;
            3'd2:    fish_width = 10'd20;
            default: fish_width = 10'd10;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fishing_game_controller_if.sv
`default_nettype none
// ============================================================================
// Module : fishing_if
// Buttons, pixel position and game status bundle between board and game.
// Rev    : 1.0
// ============================================================================
interface fishing_if;
    logic        tick;
    logic        bright;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [11:0] rgb;
    logic [2:0]  level;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        game_over;
    logic        win;

    modport master (
        output tick, bright, up, down, left, right, hCount, vCount,
        input  rgb, level, score, lives, game_over, win
    );

    modport slave (
        input  tick, bright, up, down, left, right, hCount, vCount,
        output rgb, level, score, lives, game_over, win
    );
endinterface
`default_nettype wire

// File: rtl/fishing_game_controller_renderer.sv
`default_nettype none
// ============================================================================
// Module : fishing_renderer
// Combinational pixel classifier: picks the colour of the current pixel.
// Rev    : 1.0
// ============================================================================
module fishing_renderer
    import fishing_pkg::*;
(
    input  logic        bright_i,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic [1:0]  state_i,
    input  logic [2:0]  level_i,
    input  logic [9:0]  rxpos_i,
    input  logic [9:0]  rypos_i,
    input  logic [9:0]  fxpos_i,
    input  logic [9:0]  fypos_i,
    output logic [11:0] rgb_o
);
    logic [10:0] w_h, w_v, w_rx, w_ry, w_fx, w_fy, w_hh, w_wd;
    logic        w_buoy, w_angler, w_fish, w_rod, w_sun_box;

    assign w_h  = {1'b0, hcount_i};
    assign w_v  = {1'b0, vcount_i};
    assign w_rx = {1'b0, rxpos_i};
    assign w_ry = {1'b0, rypos_i};
    assign w_fx = {1'b0, fxpos_i};
    assign w_fy = {1'b0, fypos_i};
    assign w_hh = {1'b0, fish_half_h(level_i)};
    assign w_wd = {1'b0, fish_width(level_i)};

    // Offsets are moved to the other side of each compare so nothing subtracts.
    assign w_buoy = (w_h + 11'd3 >= w_rx) && (w_h <= w_rx + 11'd3) &&
                    (w_v + 11'd3 >= {1'b0, SURFACE_Y}) && (w_v <= {1'b0, SURFACE_Y} + 11'd3);

    assign w_angler = ((w_h + 11'd125 >= w_rx) && (w_h + 11'd115 <= w_rx) &&
                       (w_v >= 11'd70) && (w_v <= 11'd90)) ||
                      ((w_h + 11'd128 >= w_rx) && (w_h + 11'd112 <= w_rx) &&
                       (w_v > 11'd90) && (w_v <= 11'd150));

    assign w_fish = ((state_i == ST_FISH) || (state_i == ST_REEL)) &&
                    (w_h >= w_fx) && (w_h < w_fx + w_wd) &&
                    (w_v + w_hh >= w_fy) && (w_v <= w_fy + w_hh);

    assign w_rod = ((w_h + 11'd110 >= w_rx) && (w_h <= w_rx) &&
                    (w_v >= 11'd72) && (w_v <= 11'd74)) ||
                   ((w_h >= w_rx) && (w_h <= w_rx + 11'd1) &&
                    (w_v >= 11'd72) && (w_v <= {1'b0, LINE_TOP})) ||
                   ((w_h == w_rx) && (w_v >= {1'b0, LINE_TOP}) && (w_v <= w_ry));

    assign w_sun_box = (w_h >= {1'b0, SUN_X}) && (w_h < {1'b0, SUN_X} + {1'b0, SUN_SIZE}) &&
                       (w_v >= {1'b0, SUN_Y}) && (w_v < {1'b0, SUN_Y} + {1'b0, SUN_SIZE});

    always_comb begin
        if (!bright_i)                                  rgb_o = BLACK;
        else if (w_buoy)                                rgb_o = BROWN;
        else if (w_angler)                              rgb_o = RED;
        else if (w_fish)                                rgb_o = ORANGE;
        else if (w_rod)                                 rgb_o = GREEN;
        else if (w_sun_box && (state_i == ST_WIN))      rgb_o = YELLOW;
        else if (w_sun_box && (state_i == ST_LOSE))     rgb_o = RED;
        else if (vcount_i >= SURFACE_Y)                 rgb_o = BLUE;
        else                                            rgb_o = WHITE;
    end
endmodule
`default_nettype wire

// File: rtl/fishing_game_controller.sv
`default_nettype none
// ============================================================================
// Module : fishing_game_controller
// Tick-gated fishing game state machine with score, lives, timeout and escape.
// Rev    : 1.0
// ============================================================================
module fishing_game_controller
    import fishing_pkg::*;
#(
    parameter int NUM_LEVELS    = 4,
    parameter int FISH_SPEED    = 2,
    parameter int ROD_SPEED     = 3,
    parameter int LINE_DROP     = 4,
    parameter int REEL_SPEED    = 2,
    parameter int TIMEOUT_TICKS = 1024,
    parameter int ESCAPE_TICKS  = 32,
    parameter int START_LIVES   = 3
) (
    input  logic      clk,
    input  logic      rst,
    fishing_if.slave  game_if
);
    logic [1:0]  state_q, state_d;
    logic [2:0]  level_q, level_d, lives_q, lives_d;
    logic [9:0]  rxpos_q, rxpos_d, rypos_q, rypos_d, fxpos_q, fxpos_d, fypos_q, fypos_d;
    logic [10:0] timer_q, timer_d;
    logic [5:0]  esc_q, esc_d;
    logic [7:0]  score_q, score_d;
    logic        w_lose_life, w_catch;
    logic [10:0] w_fx, w_fy, w_rx, w_ry, w_half, w_dist;
    logic [9:0]  w_fy_up, w_ry_up;

    assign w_fx   = {1'b0, fxpos_q};
    assign w_fy   = {1'b0, fypos_q};
    assign w_rx   = {1'b0, rxpos_q};
    assign w_ry   = {1'b0, rypos_q};
    assign w_half = {1'b0, fish_half_h(level_q)};
    assign w_dist = (w_ry >= w_fy) ? (w_ry - w_fy) : (w_fy - w_ry);
    assign w_catch = game_if.up && (w_fx <= w_rx) && (w_rx <= w_fx + w_half) && (w_dist <= w_half);

    // Reel positions after this tick; completion is judged on the new fish y.
    assign w_fy_up = !game_if.up ? fypos_q :
                     (fypos_q > 10'(REEL_SPEED)) ? fypos_q - 10'(REEL_SPEED) : 10'd0;
    assign w_ry_up = (rypos_q > 10'(REEL_SPEED)) ? rypos_q - 10'(REEL_SPEED) : 10'd0;

    always_comb begin
        state_d = state_q;  level_d = level_q;  rxpos_d = rxpos_q;  rypos_d = rypos_q;
        fxpos_d = fxpos_q;  fypos_d = fypos_q;  timer_d = timer_q;  esc_d   = esc_q;
        score_d = score_q;  lives_d = lives_q;  w_lose_life = 1'b0;
        if (game_if.tick) begin
            case (state_q)
                ST_FISH: begin
                    fypos_d = fish_y(level_q);
                    if (w_fx < {1'b0, H_MIN} + 11'(FISH_SPEED)) fxpos_d = H_MAX;
                    else                                        fxpos_d = fxpos_q - 10'(FISH_SPEED);
                    if (w_ry + 11'(LINE_DROP) <= w_fy + w_half) rypos_d = rypos_q + 10'(LINE_DROP);
                    if (game_if.right)
                        rxpos_d = (w_rx + 11'(ROD_SPEED) > {1'b0, ROD_X_MAX}) ? ROD_X_MAX : rxpos_q + 10'(ROD_SPEED);
                    else if (game_if.left)
                        rxpos_d = (w_rx < {1'b0, ROD_X_MIN} + 11'(ROD_SPEED)) ? ROD_X_MIN : rxpos_q - 10'(ROD_SPEED);
                    if (w_catch) begin
                        state_d = ST_REEL;
                        fxpos_d = rxpos_q;
                        timer_d = '0;
                        esc_d   = '0;
                    end else if (timer_q == 11'(TIMEOUT_TICKS - 1)) begin
                        w_lose_life = 1'b1;
                    end else begin
                        timer_d = timer_q + 11'd1;
                    end
                end
                ST_REEL: begin
                    fxpos_d = rxpos_q;
                    if (game_if.up) begin
                        fypos_d = w_fy_up;
                        rypos_d = w_ry_up;
                        esc_d   = '0;
                    end else begin
                        esc_d   = esc_q + 6'd1;
                    end
                    if (w_fy_up < CATCH_Y) begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        if (level_q == 3'(NUM_LEVELS - 1)) begin
                            state_d = ST_WIN;
                        end else begin
                            state_d = ST_FISH;
                            level_d = level_q + 3'd1;
                            fxpos_d = H_MAX;
                            fypos_d = fish_y(level_q + 3'd1);
                            rypos_d = SURFACE_Y;
                            timer_d = '0;
                            esc_d   = '0;
                        end
                    end else if (!game_if.up && (esc_q == 6'(ESCAPE_TICKS - 1))) begin
                        state_d = ST_FISH;
                        fxpos_d = H_MAX;
                        fypos_d = fish_y(level_q);
                        esc_d   = '0;
                        w_lose_life = 1'b1;
                    end
                end
                default: begin
                    if (game_if.left || game_if.right) begin
                        state_d = ST_FISH;
                        level_d = '0;
                        rxpos_d = ROD_X_RESET;
                        rypos_d = SURFACE_Y;
                        fxpos_d = H_MAX;
                        fypos_d = fish_y(3'd0);
                        timer_d = '0;
                        esc_d   = '0;
                        lives_d = 3'(START_LIVES);
                    end
                    if ((state_q == ST_LOSE) && game_if.down) score_d = '0;
                end
            endcase
            if (w_lose_life) begin
                if (lives_q <= 3'd1) begin
                    lives_d = '0;
                    state_d = ST_LOSE;
                end else begin
                    lives_d = lives_q - 3'd1;
                    fxpos_d = H_MAX;
                    rypos_d = SURFACE_Y;
                    timer_d = '0;
                    esc_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FISH;
            level_q <= '0;
            rxpos_q <= ROD_X_RESET;
            rypos_q <= SURFACE_Y;
            fxpos_q <= H_MAX;
            fypos_q <= fish_y(3'd0);
            timer_q <= '0;
            esc_q   <= '0;
            score_q <= '0;
            lives_q <= 3'(START_LIVES);
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            rxpos_q <= rxpos_d;
            rypos_q <= rypos_d;
            fxpos_q <= fxpos_d;
            fypos_q <= fypos_d;
            timer_q <= timer_d;
            esc_q   <= esc_d;
            score_q <= score_d;
            lives_q <= lives_d;
        end
    end

    assign game_if.level     = level_q;
    assign game_if.score     = score_q;
    assign game_if.lives     = lives_q;
    assign game_if.game_over = (state_q == ST_LOSE);
    assign game_if.win       = (state_q == ST_WIN);

    fishing_renderer u_renderer (
        .bright_i (game_if.bright),
        .hcount_i (game_if.hCount),
        .vcount_i (game_if.vCount),
        .state_i  (state_q),
        .level_i  (level_q),
        .rxpos_i  (rxpos_q),
        .rypos_i  (rypos_q),
        .fxpos_i  (fxpos_q),
        .fypos_i  (fypos_q),
        .rgb_o    (game_if.rgb)
    );
endmodule
`default_nettype wire

// File: tb/tb_fishing_game_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_fishing_game_controller
// Directed game scenario with a queued scoreboard checked on falling edges.
// Rev    : 1.0
// ============================================================================
module tb_fishing_game_controller;
    import fishing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fishing_if bus ();

    fishing_game_controller #(.NUM_LEVELS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .game_if (bus)
    );

    typedef enum int {K_RGB, K_LEVEL, K_SCORE, K_LIVES, K_GO, K_WIN,
                      K_FX, K_FY, K_RY, K_RX, K_TIMER, K_ESC} kind_e;
    typedef struct {
        string name;
        kind_e kind;
        int    val;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic int probe(input kind_e k);
        case (k)
            K_RGB:   return int'(bus.rgb);
            K_LEVEL: return int'(bus.level);
            K_SCORE: return int'(bus.score);
            K_LIVES: return int'(bus.lives);
            K_GO:    return int'(bus.game_over);
            K_WIN:   return int'(bus.win);
            K_FX:    return int'(dut.fxpos_q);
            K_FY:    return int'(dut.fypos_q);
            K_RY:    return int'(dut.rypos_q);
            K_RX:    return int'(dut.rxpos_q);
            K_TIMER: return int'(dut.timer_q);
            default: return int'(dut.esc_q);
        endcase
    endfunction

    task automatic chk(input string n, input kind_e k, input int v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = probe(e.kind);
            checks++;
            if (act != e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
            end
        end
    end

    task automatic ticks(input int n);
        @(posedge clk);
        #1 bus.tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.tick = 1'b0;
    endtask

    task automatic pix(input string n, input int h, input int v, input logic b, input int e);
        bus.hCount = 10'(h);
        bus.vCount = 10'(v);
        bus.bright = b;
        chk(n, K_RGB, e);
        @(negedge clk);
        #1 bus.bright = 1'b0;
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        bus.up = u; bus.down = d; bus.left = l; bus.right = r;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.tick = 1'b0; bus.bright = 1'b0; bus.hCount = '0; bus.vCount = '0;
        set_btn(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_level", K_LEVEL, 0);  chk("rst_lives", K_LIVES, 3);
        chk("rst_score", K_SCORE, 0);  chk("rst_go", K_GO, 0);
        chk("rst_win", K_WIN, 0);      chk("rst_fx", K_FX, 798);
        chk("rst_fy", K_FY, 470);      chk("rst_ry", K_RY, 155);
        chk("rst_rx", K_RX, 450);      chk("rst_timer", K_TIMER, 0);
        pix("px_head", 330, 80, 1'b1, int'(RED));
        pix("px_dark", 330, 80, 1'b0, int'(BLACK));
        pix("px_line", 450, 100, 1'b1, int'(GREEN));
        pix("px_fish", 800, 470, 1'b1, int'(ORANGE));
        pix("px_water", 200, 300, 1'b1, int'(BLUE));
        pix("px_sky", 200, 50, 1'b1, int'(WHITE));

        // Buttons without tick must not move anything.
        set_btn(0, 0, 1, 0);
        repeat (5) @(posedge clk);
        #1 set_btn(0, 0, 0, 0);
        chk("hold_rx", K_RX, 450);

        ticks(327);
        chk("wrap_fx_low", K_FX, 144);  chk("wrap_timer327", K_TIMER, 327);
        chk("wrap_ry", K_RY, 479);
        ticks(1);
        chk("wrap_fx_reload", K_FX, 798); chk("wrap_timer328", K_TIMER, 328);

        ticks(177);
        chk("pre_catch_fx", K_FX, 444);  chk("pre_catch_timer", K_TIMER, 505);
        set_btn(1, 0, 0, 0);
        ticks(1);
        chk("catch_fx", K_FX, 450);  chk("catch_timer", K_TIMER, 0);
        ticks(182);
        chk("reel_fy", K_FY, 106);  chk("reel_level0", K_LEVEL, 0);
        chk("reel_score0", K_SCORE, 0);
        ticks(1);
        chk("done_level", K_LEVEL, 1);  chk("done_score", K_SCORE, 1);
        chk("done_fy", K_FY, 380);      chk("done_fx", K_FX, 798);
        chk("done_ry", K_RY, 155);
        set_btn(0, 0, 0, 0);

        ticks(177);
        chk("l1_fx", K_FX, 444);  chk("l1_ry", K_RY, 387);
        set_btn(1, 0, 0, 0);
        ticks(1);
        chk("l1_catch_fx", K_FX, 450);
        set_btn(0, 0, 0, 0);
        ticks(31);
        chk("esc_count", K_ESC, 31);  chk("esc_lives_held", K_LIVES, 3);
        ticks(1);
        chk("esc_lives", K_LIVES, 2);  chk("esc_fx", K_FX, 798);
        chk("esc_level", K_LEVEL, 1);  chk("esc_fy", K_FY, 380);

        ticks(1023);
        chk("to_lives_held", K_LIVES, 2);  chk("to_timer", K_TIMER, 1023);
        ticks(1);
        chk("to_lives", K_LIVES, 1);  chk("to_timer_clr", K_TIMER, 0);
        chk("to_fx", K_FX, 798);      chk("to_ry", K_RY, 155);
        ticks(1024);
        chk("lose_lives", K_LIVES, 0);  chk("lose_go", K_GO, 1);
        chk("lose_score", K_SCORE, 1);
        pix("px_skull", 740, 75, 1'b1, int'(RED));
        set_btn(0, 1, 0, 0);
        ticks(1);
        chk("down_score", K_SCORE, 0);  chk("down_go", K_GO, 1);
        set_btn(0, 0, 0, 1);
        ticks(1);
        chk("rs_lives", K_LIVES, 3);  chk("rs_go", K_GO, 0);
        chk("rs_level", K_LEVEL, 0);  chk("rs_fx", K_FX, 798);
        set_btn(0, 0, 0, 0);

        ticks(177);
        set_btn(1, 0, 0, 0);
        ticks(1);
        ticks(183);
        chk("w_level1", K_LEVEL, 1);  chk("w_score1", K_SCORE, 1);
        set_btn(0, 0, 0, 0);
        ticks(177);
        set_btn(1, 0, 0, 0);
        ticks(1);
        ticks(137);
        chk("w_fy_edge", K_FY, 106);  chk("w_not_yet", K_WIN, 0);
        ticks(1);
        chk("w_win", K_WIN, 1);  chk("w_score2", K_SCORE, 2);
        chk("w_go", K_GO, 0);
        set_btn(0, 0, 0, 0);
        pix("px_sun", 740, 75, 1'b1, int'(YELLOW));
        pix("px_nofish", 460, 104, 1'b1, int'(WHITE));
        set_btn(0, 0, 1, 1);
        ticks(1);
        chk("wr_win", K_WIN, 0);     chk("wr_score", K_SCORE, 2);
        chk("wr_level", K_LEVEL, 0); chk("wr_lives", K_LIVES, 3);

        set_btn(0, 0, 0, 1);
        ticks(116);
        chk("rod_max", K_RX, 798);
        ticks(1);
        chk("rod_clamp_hi", K_RX, 798);
        set_btn(0, 0, 1, 1);
        ticks(1);
        chk("rod_right_wins", K_RX, 798);
        set_btn(0, 0, 1, 0);
        ticks(162);
        chk("rod_min", K_RX, 312);
        ticks(1);
        chk("rod_clamp_lo", K_RX, 312);  chk("rod_timer", K_TIMER, 281);
        set_btn(0, 0, 0, 0);

        // Reset pulse between clock edges must act without waiting for a clock.
        @(posedge clk);
        #1 bus.tick = 1'b1; rst = 1'b1;
        #2 rst = 1'b0; bus.tick = 1'b0;
        chk("arst_score", K_SCORE, 0);  chk("arst_rx", K_RX, 450);
        chk("arst_timer", K_TIMER, 0);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
